pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64: payload width; data is held, never zeroed on bubble.
REQ-002 SHALL have parameter CTRL_W, default 16: control-bit width; forced to 0 whenever the stage holds a bubble.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: upstream presents an instruction.
REQ-006 SHALL have port in_ready, output, 1: stage accepts this cycle.
REQ-007 SHALL have port in_ctrl, input, CTRL_W: control bits (RegWrite, MemWrite, Halt, etc.).
REQ-008 SHALL have port in_data, input, DATA_W: payload (PC, operands, ALU result, etc.).
REQ-009 SHALL have port flush, input, 1: squash all held and incoming entries.
REQ-010 SHALL have port out_valid, output, 1: stage presents an instruction.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts this cycle.
REQ-012 SHALL have port out_ctrl, output, CTRL_W: head-entry control; 0 when out_valid=0.
REQ-013 SHALL have port out_data, output, DATA_W: head-entry payload.
REQ-014 SHALL have port occ, output, 2: entries held (0..2).

Function
REQ-015 SHALL transfer on a port only when valid and ready are both 1 in the same cycle.
REQ-016 SHALL present an accepted entry on out_* exactly one cycle after acceptance when the stage was empty.
REQ-017 SHALL preserve order; no entry is dropped or duplicated except by flush or rst.
REQ-018 SHALL track occupancy in states EMPTY, ONE and TWO (TWO only exists with PIPE_SKID_EN).
REQ-019 SHALL follow these transitions: EMPTY->ONE on accept; ONE->EMPTY on drain without accept; ONE->ONE on drain with accept, or no activity; ONE->TWO on accept without drain; TWO->ONE on drain.
REQ-020 SHALL give flush priority over every other event: next state is EMPTY, an input accepted in the flush cycle is discarded, and out_valid=0 and occ=0 on the following cycle.
REQ-021 SHALL keep out_valid, out_ctrl and out_data stable while out_valid=1 and out_ready=0.
REQ-022 SHALL hold out_data at its last value when the stage is empty, while out_ctrl reads 0.
REQ-023 SHALL, when in_valid=1, out_ready=1 and the stage is in ONE, drain the head and load the new entry in the same cycle, leaving occ at 1.

Reset
REQ-024 SHALL, on the first edge with rst=1, set state EMPTY, out_valid=0, out_ctrl=0, out_data=0, occ=0 and all skid storage to 0.
REQ-025 SHALL drive in_ready=0 while rst=1, and discard in_valid during that time.
REQ-026 SHALL take rst priority over flush, and SHALL discard any held entry if rst asserts mid-stall.

Configuration
REQ-027 SHALL, with PIPE_SKID_EN defined, add a second (skid) entry and drive in_ready from a register: in_ready=1 iff occ<2, with no combinational path from out_ready to in_ready.
REQ-028 SHALL, without PIPE_SKID_EN, have one entry and drive in_ready = !rst & (!out_valid | out_ready) combinationally; occ never exceeds 1.
REQ-029 SHALL produce identical transfer sequences under both builds for any stimulus in which out_ready never drops while out_valid=1.

Structure
REQ-030 SHALL place the occupancy-state typedef (EMPTY/ONE/TWO) and the default DATA_W/CTRL_W constants in the shared package pipe_pkg.
REQ-031 SHALL implement each storage entry as sub-module pipe_slot (valid, ctrl and data with load and clear), instantiated once or twice.

Verification
REQ-032 SHALL cover streaming: out_ready=1, in_valid=1 for 8 cycles, ctrl=i, data=0x100+i -> out_valid from cycle 1, same sequence in order, occ=1 throughout.
REQ-033 SHALL cover stall: entry A is held with out_ready=0 for 5 cycles -> out_data=A stable for 5 cycles; with skid, entry B is accepted, occ=2, in_ready=0, then out_ready=1 drains A then B.
REQ-034 SHALL cover flush while full: occ=2, flush=1 with in_valid=1 (ctrl=0xFFFF) -> next cycle out_valid=0, out_ctrl=0, occ=0, and the incoming entry never appears.
REQ-035 SHALL cover bubble control: out_valid=0 after a drain -> out_ctrl=0 while out_data keeps the last payload.
REQ-036 SHALL cover reset mid-stall: occ=1, out_ready=0, rst pulsed for 1 cycle -> next cycle all outputs 0, in_ready=0 during rst and 1 afterwards.
REQ-037 SHALL cover simultaneous drain and accept in ONE with in_valid=1 and out_ready=1 for 1 cycle -> the new entry is presented next cycle and occ stays 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage register.
// PIPE_SKID_EN (when defined elsewhere) enables the second, skid entry.
package pipe_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int CTRL_W_DEF = 16;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

    function automatic logic [1:0] occ_count(input occ_state_e s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle around pipe_stage_reg (upstream, downstream, flush, occupancy).
// PIPE_SKID_EN changes only the stage behind it, not this bundle.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
);
    // A transfer happens on a side only in a cycle where its valid and ready are
    // both 1; a producer holds valid/ctrl/data steady until that cycle arrives.
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occ;
    occ_state_e        dbg_state;

    modport slave (
        input  in_valid, in_ctrl, in_data, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occ, dbg_state
    );

    modport master (
        output in_valid, in_ctrl, in_data, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occ, dbg_state
    );

endinterface

// File: rtl/pipe_slot.sv
// One storage entry: valid, ctrl and data with load and clear.
// Clear wins over load; clear zeroes valid/ctrl but keeps data.
module pipe_slot #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load) begin
            valid_d = 1'b1;
            ctrl_d  = ld_ctrl;
            data_d  = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign ctrl  = ctrl_q;
    assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with flush; bubbles carry zero ctrl.
// Define PIPE_SKID_EN for a two-entry stage with a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_reg_if.slave  bus
);
    occ_state_e        state_q, state_d;
    logic              accept, drain, in_ready;
    logic              head_load, head_clear, head_valid;
    logic [CTRL_W-1:0] head_ctrl, head_ld_ctrl;
    logic [DATA_W-1:0] head_data, head_ld_data;

    assign drain  = head_valid & bus.out_ready;
    assign accept = bus.in_valid & in_ready;

`ifdef PIPE_SKID_EN
    logic              skid_load, skid_clear, skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_ready_q, in_ready_d;

    // in_ready looks only at the next occupancy, never at out_ready.
    assign in_ready_d = (state_d != OCC_TWO);

    always_ff @(posedge clk) begin
        if (rst) in_ready_q <= 1'b1;
        else     in_ready_q <= in_ready_d;
    end

    assign in_ready = in_ready_q & ~rst;
`else
    assign in_ready = ~rst & (~head_valid | bus.out_ready);
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= OCC_EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OCC_EMPTY: if (accept) state_d = OCC_ONE;
            OCC_ONE: begin
                if (drain && !accept) state_d = OCC_EMPTY;
`ifdef PIPE_SKID_EN
                else if (accept && !drain) state_d = OCC_TWO;
`endif
            end
            OCC_TWO: if (drain) state_d = OCC_ONE;
            default: state_d = OCC_EMPTY;
        endcase
        if (bus.flush) state_d = OCC_EMPTY;
    end

    always_comb begin
        head_load    = 1'b0;
        head_clear   = bus.flush;
        head_ld_ctrl = bus.in_ctrl;
        head_ld_data = bus.in_data;
`ifdef PIPE_SKID_EN
        skid_load    = 1'b0;
        skid_clear   = bus.flush;
`endif
        case (state_q)
            OCC_EMPTY: head_load = accept;
            OCC_ONE: begin
                head_load = accept & drain;
                if (drain && !accept) head_clear = 1'b1;
`ifdef PIPE_SKID_EN
                skid_load = accept & ~drain;
`endif
            end
`ifdef PIPE_SKID_EN
            // Draining from TWO promotes the skid entry into the head.
            OCC_TWO: begin
                head_load    = drain;
                head_ld_ctrl = skid_ctrl;
                head_ld_data = skid_data;
                if (drain) skid_clear = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_head (
        .clk     (clk),
        .rst     (rst),
        .load    (head_load),
        .clear   (head_clear),
        .ld_ctrl (head_ld_ctrl),
        .ld_data (head_ld_data),
        .valid   (head_valid),
        .ctrl    (head_ctrl),
        .data    (head_data)
    );

`ifdef PIPE_SKID_EN
    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clear   (skid_clear),
        .ld_ctrl (bus.in_ctrl),
        .ld_data (bus.in_data),
        .valid   (skid_valid),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
    );

    logic unused_skid_valid;
    assign unused_skid_valid = skid_valid;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = head_valid;
    assign bus.out_ctrl  = head_ctrl;
    assign bus.out_data  = head_data;
    assign bus.occ       = occ_count(state_q);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a queue model.
// Works in either build; PIPE_SKID_EN selects the two-entry expectations.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 16;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents plus the payload left showing on a bubble.
    logic [DATA_W-1:0] exp_q[$];
    logic [CTRL_W-1:0] exp_ctrl_q[$];
    logic [DATA_W-1:0] last_data = '0;
    logic              exp_in_ready, exp_out_valid;
    logic [CTRL_W-1:0] exp_out_ctrl;
    logic [DATA_W-1:0] exp_out_data;
    logic [1:0]        exp_occ;

    task automatic drive(input logic r, input logic v, input logic [CTRL_W-1:0] c,
                         input logic [DATA_W-1:0] d, input logic f, input logic o);
        @(negedge clk);
        rst = r; bus.in_valid = v; bus.in_ctrl = c; bus.in_data = d;
        bus.flush = f; bus.out_ready = o;
        #1;
        exp_out_valid = (exp_q.size() != 0);
        exp_out_ctrl  = exp_out_valid ? exp_ctrl_q[0] : '0;
        exp_out_data  = exp_out_valid ? exp_q[0] : last_data;
        exp_occ       = 2'(exp_q.size());
        if (SKID) exp_in_ready = !r && (exp_q.size() < 2);
        else      exp_in_ready = !r && (!exp_out_valid || o);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            exp_q.delete(); exp_ctrl_q.delete(); last_data = '0;
        end else begin
            if (exp_q.size() != 0) last_data = exp_q[0];
            if (bus.flush) begin
                exp_q.delete(); exp_ctrl_q.delete();
            end else begin
                if (exp_out_valid && bus.out_ready) begin
                    void'(exp_q.pop_front()); void'(exp_ctrl_q.pop_front());
                end
                if (bus.in_valid && exp_in_ready) begin
                    exp_q.push_back(bus.in_data); exp_ctrl_q.push_back(bus.in_ctrl);
                end
            end
        end
    endtask

    task automatic test_reset();
        drive(1, 1, 16'h1234, 64'h55, 0, 0);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        tick();
        drive(1, 0, '0, '0, 0, 1);
        tick();
        drive(0, 0, '0, '0, 0, 1);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_ctrl !== '0) begin errors++; $display("FAIL reset_out_ctrl: got %h want 0", bus.out_ctrl); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
        checks++; if (bus.occ !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", bus.occ); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready); end
        tick();
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, CTRL_W'(i), DATA_W'(64'h100 + i), 0, 1);
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
            if (i > 0) begin
                checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, bus.out_valid); end
                checks++; if (bus.out_ctrl !== CTRL_W'(i - 1)) begin errors++; $display("FAIL stream_ctrl[%0d]: got %h want %h", i, bus.out_ctrl, CTRL_W'(i - 1)); end
                checks++; if (bus.out_data !== DATA_W'(64'h100 + i - 1)) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, bus.out_data, DATA_W'(64'h100 + i - 1)); end
                checks++; if (bus.occ !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, bus.occ); end
            end
            tick();
        end
        drive(0, 0, '0, '0, 0, 1);
        checks++; if (bus.out_data !== DATA_W'(64'h107)) begin errors++; $display("FAIL stream_last: got %h want 107", bus.out_data); end
        tick();
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] a, b;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        drive(0, 1, 16'hA, a, 0, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, '0, '0, 0, 0);
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== a) begin errors++; $display("FAIL stall_hold[%0d]: got %b/%h want 1/%h", k, bus.out_valid, bus.out_data, a); end
            checks++; if (bus.out_ctrl !== 16'hA) begin errors++; $display("FAIL stall_ctrl[%0d]: got %h want a", k, bus.out_ctrl); end
            tick();
        end
        drive(0, 1, 16'hB, b, 0, 0);
        checks++; if (bus.in_ready !== exp_in_ready) begin errors++; $display("FAIL stall_offer_ready: got %b want %b", bus.in_ready, exp_in_ready); end
        tick();
        drive(0, 0, '0, '0, 0, 0);
        checks++; if (bus.occ !== (SKID ? 2'd2 : 2'd1)) begin errors++; $display("FAIL stall_occ: got %0d want %0d", bus.occ, SKID ? 2 : 1); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_full_ready: got %b want 0", bus.in_ready); end
        tick();
        drive(0, 0, '0, '0, 0, 1);
        checks++; if (bus.out_data !== a) begin errors++; $display("FAIL stall_drain_a: got %h want %h", bus.out_data, a); end
        tick();
        drive(0, 0, '0, '0, 0, 1);
        checks++; if (bus.out_valid !== SKID || bus.out_data !== (SKID ? b : a)) begin errors++; $display("FAIL stall_drain_b: got %b/%h want %b/%h", bus.out_valid, bus.out_data, SKID, SKID ? b : a); end
        tick();
    endtask

    task automatic test_flush_full();
        drive(0, 1, 16'h11, 64'h11, 0, 0);
        tick();
        drive(0, 1, 16'h22, 64'h22, 0, 0);
        tick();
        drive(0, 1, 16'hFFFF, 64'hDEAD, 1, 0);
        checks++; if (bus.occ !== (SKID ? 2'd2 : 2'd1)) begin errors++; $display("FAIL flush_pre_occ: got %0d want %0d", bus.occ, SKID ? 2 : 1); end
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, '0, '0, 0, 1);
            checks++; if (bus.out_valid !== 1'b0 || bus.out_ctrl !== '0 || bus.occ !== 2'd0) begin errors++; $display("FAIL flush_empty[%0d]: got v=%b c=%h o=%0d want 0/0/0", k, bus.out_valid, bus.out_ctrl, bus.occ); end
            checks++; if (bus.out_data !== 64'h11) begin errors++; $display("FAIL flush_data_held[%0d]: got %h want 11", k, bus.out_data); end
            tick();
        end
    endtask

    task automatic test_bubble();
        logic [DATA_W-1:0] x;
        x = {$urandom, $urandom};
        drive(0, 1, 16'h5A5A, x, 0, 1);
        tick();
        drive(0, 0, '0, '0, 0, 1);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bubble_present: got %b want 1", bus.out_valid); end
        tick();
        drive(0, 0, '0, '0, 0, 1);
        checks++; if (bus.out_valid !== 1'b0 || bus.out_ctrl !== '0) begin errors++; $display("FAIL bubble_ctrl: got v=%b c=%h want 0/0", bus.out_valid, bus.out_ctrl); end
        checks++; if (bus.out_data !== x) begin errors++; $display("FAIL bubble_data: got %h want %h", bus.out_data, x); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        drive(0, 1, 16'h77, 64'h77, 0, 0);
        tick();
        drive(0, 0, '0, '0, 0, 0);
        checks++; if (bus.occ !== 2'd1) begin errors++; $display("FAIL rst_stall_occ: got %0d want 1", bus.occ); end
        tick();
        drive(1, 1, 16'h99, 64'h99, 1, 0);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_stall_in_ready: got %b want 0", bus.in_ready); end
        tick();
        drive(0, 0, '0, '0, 0, 0);
        checks++; if (bus.out_valid !== 1'b0 || bus.out_ctrl !== '0 || bus.out_data !== '0 || bus.occ !== 2'd0) begin errors++; $display("FAIL rst_stall_outputs: got v=%b c=%h d=%h o=%0d want all 0", bus.out_valid, bus.out_ctrl, bus.out_data, bus.occ); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_stall_release: got %b want 1", bus.in_ready); end
        tick();
    endtask

    task automatic test_drain_accept();
        drive(0, 1, 16'h0C01, 64'hC01, 0, 1);
        tick();
        drive(0, 1, 16'h0C02, 64'hC02, 0, 1);
        checks++; if (bus.occ !== 2'd1 || bus.out_data !== 64'hC01) begin errors++; $display("FAIL da_before: got o=%0d d=%h want 1/c01", bus.occ, bus.out_data); end
        tick();
        drive(0, 0, '0, '0, 0, 0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_ctrl !== 16'h0C02 || bus.out_data !== 64'hC02) begin errors++; $display("FAIL da_next: got v=%b c=%h d=%h want 1/c02/c02", bus.out_valid, bus.out_ctrl, bus.out_data); end
        checks++; if (bus.occ !== 2'd1) begin errors++; $display("FAIL da_occ: got %0d want 1", bus.occ); end
        tick();
        drive(0, 0, '0, '0, 0, 1);
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, CTRL_W'($urandom),
                  {$urandom, $urandom}, $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0);
            checks++; if (bus.in_ready !== exp_in_ready) begin errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", n, bus.in_ready, exp_in_ready); end
            checks++; if (bus.out_valid !== exp_out_valid) begin errors++; $display("FAIL rand_out_valid[%0d]: got %b want %b", n, bus.out_valid, exp_out_valid); end
            checks++; if (bus.out_ctrl !== exp_out_ctrl) begin errors++; $display("FAIL rand_out_ctrl[%0d]: got %h want %h", n, bus.out_ctrl, exp_out_ctrl); end
            checks++; if (bus.out_data !== exp_out_data) begin errors++; $display("FAIL rand_out_data[%0d]: got %h want %h", n, bus.out_data, exp_out_data); end
            checks++; if (bus.occ !== exp_occ) begin errors++; $display("FAIL rand_occ[%0d]: got %0d want %0d", n, bus.occ, exp_occ); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_ctrl = '0; bus.in_data = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_stall();
        test_flush_full();
        test_bubble();
        test_reset_mid_stall();
        test_drain_accept();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
